// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller and its datapath:
// FSM states, one-hot instruction classes, opcode/func values and mux select codes.
package multicycle_controller_pkg;

    localparam int OP_W   = 6;
    localparam int FUNC_W = 6;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_ACC,
        S_MEM_WB,
        S_BRANCH,
        S_JUMP
    } state_e;

    // One-hot so the datapath can test a class with a single bit if it wants to
    typedef enum logic [8:0] {
        CLS_NONE = 9'h000,
        CLS_ADDU = 9'h001,
        CLS_SUBU = 9'h002,
        CLS_ORI  = 9'h004,
        CLS_LW   = 9'h008,
        CLS_SW   = 9'h010,
        CLS_BEQ  = 9'h020,
        CLS_LUI  = 9'h040,
        CLS_JAL  = 9'h080,
        CLS_JR   = 9'h100
    } iclass_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [FUNC_W-1:0] FUNC_ADDU = 6'b100001;
    localparam logic [FUNC_W-1:0] FUNC_SUBU = 6'b100011;
    localparam logic [FUNC_W-1:0] FUNC_JR   = 6'b001000;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] NPCIMM_NONE  = 2'b00;
    localparam logic [1:0] NPCIMM_IMM26 = 2'b01;
    localparam logic [1:0] NPCIMM_GRF   = 2'b10;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;

    localparam logic [2:0] EXT_NONE     = 3'b000;
    localparam logic [2:0] EXT_ZERO     = 3'b001;
    localparam logic [2:0] EXT_SIGN     = 3'b010;
    localparam logic [2:0] EXT_SIGN_SH2 = 3'b011;
    localparam logic [2:0] EXT_LUI      = 3'b100;

    localparam logic ALUB_EXT = 1'b0;
    localparam logic ALUB_RT  = 1'b1;

    localparam logic [1:0] A3_RT = 2'b00;
    localparam logic [1:0] A3_RD = 2'b01;
    localparam logic [1:0] A3_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_EXT = 2'b10;
    localparam logic [1:0] WD_PC4 = 2'b11;

    function automatic logic isAluClass(iclass_e c);
        return (c == CLS_ADDU) || (c == CLS_SUBU) || (c == CLS_ORI) || (c == CLS_LUI);
    endfunction

    function automatic logic isMemClass(iclass_e c);
        return (c == CLS_LW) || (c == CLS_SW);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath/memories (slave).
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    import multicycle_controller_pkg::*;

    logic [OP_W-1:0]   opcode;
    logic [FUNC_W-1:0] func;
    logic              zero;
    logic              imem_ready;
    logic              dmem_ready;

    logic              imem_req;
    logic              dmem_req;
    logic              IRWE;
    logic              PCWE;
    logic              GRFWE;
    logic              DMWE;
    logic [1:0]        NPCOp;
    logic [1:0]        NPCIMM_MUXOp;
    logic [2:0]        ALUOp;
    logic [2:0]        EXTOp;
    logic              ALUB_MUXOp;
    logic [1:0]        GRFA3_MUXOp;
    logic [1:0]        GRFWD_MUXOp;
    logic              retire;
    logic              illegal;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        input  opcode, func, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, IRWE, PCWE, GRFWE, DMWE,
               NPCOp, NPCIMM_MUXOp, ALUOp, EXTOp, ALUB_MUXOp,
               GRFA3_MUXOp, GRFWD_MUXOp, retire, illegal, retired_cnt
    );

    modport slave (
        output opcode, func, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, IRWE, PCWE, GRFWE, DMWE,
               NPCOp, NPCIMM_MUXOp, ALUOp, EXTOp, ALUB_MUXOp,
               GRFA3_MUXOp, GRFWD_MUXOp, retire, illegal, retired_cnt
    );

endinterface

// File: rtl/multicycle_controller_instr_class_decode.sv
// Combinational opcode/func to one-hot instruction class decoder; anything outside
// the MIPS-lite subset maps to CLS_NONE and raises the illegal flag.
module multicycle_controller_instr_class_decode
    import multicycle_controller_pkg::*;
(
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [FUNC_W-1:0] func_i,
    output iclass_e           class_o,
    output logic              illegal_o
);

    always_comb begin
        class_o = CLS_NONE;
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    FUNC_ADDU: class_o = CLS_ADDU;
                    FUNC_SUBU: class_o = CLS_SUBU;
                    FUNC_JR:   class_o = CLS_JR;
                    default:   class_o = CLS_NONE;
                endcase
            end
            OP_ORI:  class_o = CLS_ORI;
            OP_LW:   class_o = CLS_LW;
            OP_SW:   class_o = CLS_SW;
            OP_BEQ:  class_o = CLS_BEQ;
            OP_LUI:  class_o = CLS_LUI;
            OP_JAL:  class_o = CLS_JAL;
            default: class_o = CLS_NONE;
        endcase
    end

    assign illegal_o = (class_o == CLS_NONE);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-lite controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and selects, and counts retired instructions.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_controller_if.master   ctrl_io
);

    state_e           state_q, state_d;
    iclass_e          cls_q, cls_d;
    iclass_e          decCls;
    logic             decIllegal;
    logic [CNT_W-1:0] retiredCnt_q, retiredCnt_d;

    logic       imemReq, dmemReq, irWe, pcWe, grfWe, dmWe;
    logic [1:0] npcOp, npcImmOp, grfA3Op, grfWdOp;
    logic [2:0] aluOp, extOp;
    logic       aluBOp, retire, illegal;

    multicycle_controller_instr_class_decode u_instr_class_decode (
        .opcode_i  (ctrl_io.opcode),
        .func_i    (ctrl_io.func),
        .class_o   (decCls),
        .illegal_o (decIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            cls_q        <= CLS_NONE;
            retiredCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            retiredCnt_q <= retiredCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        imemReq  = 1'b0;
        dmemReq  = 1'b0;
        irWe     = 1'b0;
        pcWe     = 1'b0;
        grfWe    = 1'b0;
        dmWe     = 1'b0;
        npcOp    = NPC_PC4;
        npcImmOp = NPCIMM_NONE;
        aluOp    = ALU_NONE;
        extOp    = EXT_NONE;
        aluBOp   = ALUB_EXT;
        grfA3Op  = A3_RT;
        grfWdOp  = WD_ALU;
        retire   = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                imemReq = 1'b1;
                if (ctrl_io.imem_ready) begin
                    irWe    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = decCls;
                // An undefined instruction is skipped: PC advances but nothing retires
                if (decIllegal) begin
                    illegal = 1'b1;
                    pcWe    = 1'b1;
                    npcOp   = NPC_PC4;
                    state_d = S_FETCH;
                end else if (isAluClass(decCls)) begin
                    state_d = S_EXEC;
                end else if (isMemClass(decCls)) begin
                    state_d = S_MEM_ADDR;
                end else if (decCls == CLS_BEQ) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_JUMP;
                end
            end
            S_EXEC: begin
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                grfWe   = 1'b1;
                pcWe    = 1'b1;
                npcOp   = NPC_PC4;
                grfA3Op = ((cls_q == CLS_ADDU) || (cls_q == CLS_SUBU)) ? A3_RD : A3_RT;
                grfWdOp = (cls_q == CLS_LUI) ? WD_EXT : WD_ALU;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                state_d = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                dmemReq = 1'b1;
                dmWe    = (cls_q == CLS_SW);
                if (ctrl_io.dmem_ready) begin
                    if (cls_q == CLS_LW) begin
                        state_d = S_MEM_WB;
                    end else begin
                        pcWe    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM_WB: begin
                grfWe   = 1'b1;
                grfA3Op = A3_RT;
                grfWdOp = WD_DM;
                pcWe    = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                aluOp   = ALU_SUB;
                aluBOp  = ALUB_RT;
                extOp   = EXT_SIGN_SH2;
                pcWe    = 1'b1;
                npcOp   = ctrl_io.zero ? NPC_BRANCH : NPC_PC4;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcWe     = 1'b1;
                npcOp    = NPC_JUMP;
                npcImmOp = (cls_q == CLS_JAL) ? NPCIMM_IMM26 : NPCIMM_GRF;
                if (cls_q == CLS_JAL) begin
                    grfWe   = 1'b1;
                    grfA3Op = A3_RA;
                    grfWdOp = WD_PC4;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // ALU/EXT controls set up in EXEC are held through ALU_WB so the result stays stable
        if ((state_q == S_EXEC) || (state_q == S_ALU_WB)) begin
            case (cls_q)
                CLS_ADDU: begin
                    aluOp  = ALU_ADD;
                    aluBOp = ALUB_RT;
                end
                CLS_SUBU: begin
                    aluOp  = ALU_SUB;
                    aluBOp = ALUB_RT;
                end
                CLS_ORI: begin
                    aluOp  = ALU_OR;
                    extOp  = EXT_ZERO;
                    aluBOp = ALUB_EXT;
                end
                CLS_LUI: begin
                    extOp = EXT_LUI;
                end
                default: begin
                    aluOp = ALU_NONE;
                end
            endcase
        end

        if ((state_q == S_MEM_ADDR) || (state_q == S_MEM_ACC)) begin
            aluOp  = ALU_ADD;
            extOp  = EXT_SIGN;
            aluBOp = ALUB_EXT;
        end
    end

    assign retiredCnt_d = retire ? (retiredCnt_q + CNT_W'(1)) : retiredCnt_q;

    // Outputs are forced low while reset is held, even though the state register already reads FETCH
    assign ctrl_io.imem_req     = rst_n & imemReq;
    assign ctrl_io.dmem_req     = rst_n & dmemReq;
    assign ctrl_io.IRWE         = rst_n & irWe;
    assign ctrl_io.PCWE         = rst_n & pcWe;
    assign ctrl_io.GRFWE        = rst_n & grfWe;
    assign ctrl_io.DMWE         = rst_n & dmWe;
    assign ctrl_io.NPCOp        = rst_n ? npcOp    : 2'b00;
    assign ctrl_io.NPCIMM_MUXOp = rst_n ? npcImmOp : 2'b00;
    assign ctrl_io.ALUOp        = rst_n ? aluOp    : 3'b000;
    assign ctrl_io.EXTOp        = rst_n ? extOp    : 3'b000;
    assign ctrl_io.ALUB_MUXOp   = rst_n & aluBOp;
    assign ctrl_io.GRFA3_MUXOp  = rst_n ? grfA3Op  : 2'b00;
    assign ctrl_io.GRFWD_MUXOp  = rst_n ? grfWdOp  : 2'b00;
    assign ctrl_io.retire       = rst_n & retire;
    assign ctrl_io.illegal      = rst_n & illegal;
    assign ctrl_io.retired_cnt  = retiredCnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a memory-model driver issues random
// instructions and wait states, a monitor checks each completed instruction.
module tb_multicycle_controller;

    localparam int CNT_W    = 4;
    localparam int CLK_HALF = 5;

    logic clk = 1'b0;
    logic rst_n;

    multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_io (bus)
    );

    always #CLK_HALF clk = ~clk;

    typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_ILL} kind_e;

    typedef struct {
        kind_e      kind;
        int         lat;
        int         irweCyc;
        logic [1:0] npc;
        bit         chkImm;
        logic [1:0] npcImm;
        int         grfweCnt;
        logic [1:0] a3;
        logic [1:0] wd;
        bit         chkAluOp;
        logic [2:0] aluOp;
        bit         chkExt;
        logic [2:0] extOp;
        bit         chkB;
        logic       aluB;
        int         dmreqCnt;
        int         dmweCnt;
        int         retireCnt;
        int         illegalCnt;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   errors   = 0;
    int   doneCnt  = 0;
    int   cntModel = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({bus.imem_req, bus.dmem_req, bus.IRWE, bus.PCWE, bus.GRFWE, bus.DMWE,
                    bus.NPCOp, bus.NPCIMM_MUXOp, bus.ALUOp, bus.EXTOp, bus.ALUB_MUXOp,
                    bus.GRFA3_MUXOp, bus.GRFWD_MUXOp, bus.retire, bus.illegal, bus.retired_cnt});
    endfunction

    function automatic bit isLegal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h21) || (fn == 6'h23) || (fn == 6'h08);
        return (op == 6'h0D) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
               (op == 6'h0F) || (op == 6'h03);
    endfunction

    task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom_range(0, 63));
        case (k)
            K_ADDU: begin op = 6'h00; fn = 6'h21; end
            K_SUBU: begin op = 6'h00; fn = 6'h23; end
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            K_ORI:  op = 6'h0D;
            K_LUI:  op = 6'h0F;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_JAL:  op = 6'h03;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (isLegal(op, fn)) begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                end
            end
        endcase
    endtask

    // Reference model: completion cycle and control values from the instruction's class rules
    function automatic exp_t buildExp(input kind_e k, input int wI, input int wD, input logic zv);
        exp_t e;
        e.kind = k; e.lat = wI + 2; e.irweCyc = wI + 1;
        e.npc = 2'b00; e.chkImm = 0; e.npcImm = 2'b00;
        e.grfweCnt = 0; e.a3 = 2'b00; e.wd = 2'b00;
        e.chkAluOp = 0; e.aluOp = 3'b000; e.chkExt = 0; e.extOp = 3'b000; e.chkB = 0; e.aluB = 1'b0;
        e.dmreqCnt = 0; e.dmweCnt = 0; e.retireCnt = 1; e.illegalCnt = 0;
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                e.lat += 2;
                e.grfweCnt = 1;
                e.a3 = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
                e.wd = (k == K_LUI) ? 2'b10 : 2'b00;
                if (k == K_ADDU) begin e.chkAluOp = 1; e.aluOp = 3'b001; e.chkB = 1; e.aluB = 1; end
                if (k == K_SUBU) begin e.chkAluOp = 1; e.aluOp = 3'b010; e.chkB = 1; e.aluB = 1; end
                if (k == K_ORI)  begin e.chkAluOp = 1; e.aluOp = 3'b011; e.chkExt = 1; e.extOp = 3'b001;
                                       e.chkB = 1; e.aluB = 0; end
                if (k == K_LUI)  begin e.chkExt = 1; e.extOp = 3'b100; end
            end
            K_LW: begin
                e.lat += 3 + wD; e.grfweCnt = 1; e.a3 = 2'b00; e.wd = 2'b01; e.dmreqCnt = wD + 1;
            end
            K_SW: begin
                e.lat += 2 + wD; e.dmreqCnt = wD + 1; e.dmweCnt = wD + 1;
                e.chkAluOp = 1; e.aluOp = 3'b001; e.chkExt = 1; e.extOp = 3'b010; e.chkB = 1; e.aluB = 0;
            end
            K_BEQ: begin
                e.lat += 1; e.npc = zv ? 2'b01 : 2'b00;
                e.chkAluOp = 1; e.aluOp = 3'b010; e.chkExt = 1; e.extOp = 3'b011; e.chkB = 1; e.aluB = 1;
            end
            K_JAL: begin
                e.lat += 1; e.npc = 2'b10; e.chkImm = 1; e.npcImm = 2'b01;
                e.grfweCnt = 1; e.a3 = 2'b10; e.wd = 2'b11;
            end
            K_JR: begin
                e.lat += 1; e.npc = 2'b10; e.chkImm = 1; e.npcImm = 2'b10;
            end
            default: begin
                e.retireCnt = 0; e.illegalCnt = 1; e.npc = 2'b00;
            end
        endcase
        return e;
    endfunction

    // Called on a falling edge; plays instruction and data memory until the monitor sees completion
    task automatic applyStimulus(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                                 input int wI, input int wD, input logic zv, output bit ok);
        int start;
        int guard;
        int iSeen;
        int dSeen;
        expQ.push_back(buildExp(k, wI, wD, zv));
        bus.opcode = op;
        bus.func   = fn;
        bus.zero   = zv;
        start = doneCnt; guard = 0; iSeen = 0; dSeen = 0; ok = 1'b1;
        while (doneCnt == start) begin
            if (guard == 60) begin
                ok = 1'b0;
                break;
            end
            if (bus.imem_req) begin
                bus.imem_ready = (iSeen == wI);
                iSeen++;
            end else begin
                bus.imem_ready = 1'($urandom_range(0, 1));
            end
            if (bus.dmem_req) begin
                bus.dmem_ready = (dSeen == wD);
                dSeen++;
            end else begin
                bus.dmem_ready = 1'($urandom_range(0, 1));
            end
            guard++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_%s: got no completion expected one within 60 cycles", k.name());
        end
    endtask

    initial begin : monitor
        exp_t e;
        int cyc, irweCnt, irweAt, grfweCnt, dmreqCnt, dmweCnt, retCnt, illCnt, both;
        cyc = 0; irweCnt = 0; irweAt = 0; grfweCnt = 0; dmreqCnt = 0; dmweCnt = 0;
        retCnt = 0; illCnt = 0; both = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                cyc = 0; irweCnt = 0; irweAt = 0; grfweCnt = 0; dmreqCnt = 0; dmweCnt = 0;
                retCnt = 0; illCnt = 0; both = 0;
            end else begin
                cyc++;
                if (bus.IRWE)     begin irweCnt++; irweAt = cyc; end
                if (bus.GRFWE)    grfweCnt++;
                if (bus.dmem_req) dmreqCnt++;
                if (bus.DMWE)     dmweCnt++;
                if (bus.retire)   retCnt++;
                if (bus.illegal)  illCnt++;
                if (bus.GRFWE && bus.DMWE) both = 1;
                if (bus.PCWE) begin
                    if (expQ.size() == 0) begin
                        checkOutput("pcwe_without_instruction", 32'(0), 32'(1));
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({e.kind.name(), "/latency"}, 32'(cyc), 32'(e.lat));
                        checkOutput({e.kind.name(), "/irwe_count"}, 32'(irweCnt), 32'(1));
                        checkOutput({e.kind.name(), "/irwe_cycle"}, 32'(irweAt), 32'(e.irweCyc));
                        checkOutput({e.kind.name(), "/npcop"}, 32'(bus.NPCOp), 32'(e.npc));
                        checkOutput({e.kind.name(), "/grfwe_count"}, 32'(grfweCnt), 32'(e.grfweCnt));
                        checkOutput({e.kind.name(), "/dmem_req_cycles"}, 32'(dmreqCnt), 32'(e.dmreqCnt));
                        checkOutput({e.kind.name(), "/dmwe_cycles"}, 32'(dmweCnt), 32'(e.dmweCnt));
                        checkOutput({e.kind.name(), "/retire_count"}, 32'(retCnt), 32'(e.retireCnt));
                        checkOutput({e.kind.name(), "/illegal_count"}, 32'(illCnt), 32'(e.illegalCnt));
                        checkOutput({e.kind.name(), "/grfwe_dmwe_excl"}, 32'(both), 32'(0));
                        checkOutput({e.kind.name(), "/retired_cnt"}, 32'(bus.retired_cnt), 32'(cntModel));
                        if (e.chkImm)   checkOutput({e.kind.name(), "/npcimm"}, 32'(bus.NPCIMM_MUXOp), 32'(e.npcImm));
                        if (e.grfweCnt != 0) begin
                            checkOutput({e.kind.name(), "/grfa3"}, 32'(bus.GRFA3_MUXOp), 32'(e.a3));
                            checkOutput({e.kind.name(), "/grfwd"}, 32'(bus.GRFWD_MUXOp), 32'(e.wd));
                        end
                        if (e.chkAluOp) checkOutput({e.kind.name(), "/aluop"}, 32'(bus.ALUOp), 32'(e.aluOp));
                        if (e.chkExt)   checkOutput({e.kind.name(), "/extop"}, 32'(bus.EXTOp), 32'(e.extOp));
                        if (e.chkB)     checkOutput({e.kind.name(), "/alub"}, 32'(bus.ALUB_MUXOp), 32'(e.aluB));
                        if (e.retireCnt != 0) cntModel = (cntModel + 1) % (1 << CNT_W);
                    end
                    cyc = 0; irweCnt = 0; irweAt = 0; grfweCnt = 0; dmreqCnt = 0; dmweCnt = 0;
                    retCnt = 0; illCnt = 0; both = 0;
                    doneCnt++;
                end
            end
        end
    end

    task automatic resetMidMemAcc();
        logic [5:0] op;
        logic [5:0] fn;
        int seenAcc;
        int guard;
        encode(K_LW, op, fn);
        bus.opcode = op;
        bus.func   = fn;
        seenAcc = 0; guard = 0;
        while (seenAcc < 2 && guard < 30) begin
            if (bus.dmem_req) seenAcc++;
            bus.imem_ready = bus.imem_req;
            bus.dmem_ready = 1'b0;
            guard++;
            if (seenAcc < 2) @(negedge clk);
        end
        checkOutput("reach_mem_acc", 32'(seenAcc), 32'(2));
        rst_n = 1'b0;
        bus.imem_ready = 1'b1;
        #1;
        checkOutput("reset_mid_acc_outputs", outVec(), 32'(0));
        cntModel = 0;
        @(negedge clk);
        #1;
        checkOutput("reset_held_outputs", outVec(), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_imem_req", 32'(bus.imem_req), 32'(1));
        checkOutput("post_reset_retired_cnt", 32'(bus.retired_cnt), 32'(0));
    endtask

    initial begin : stimulus
        logic [5:0] op;
        logic [5:0] fn;
        bit ok;
        kind_e k;
        ok = 1'b1;
        rst_n = 1'b0;
        bus.opcode = '0; bus.func = '0; bus.zero = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs", outVec(), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        encode(K_ADDU, op, fn); applyStimulus(K_ADDU, op, fn, 0, 0, 1'b0, ok);
        if (ok) begin encode(K_LW, op, fn);  applyStimulus(K_LW,  op, fn, 2, 3, 1'b0, ok); end
        if (ok) begin encode(K_BEQ, op, fn); applyStimulus(K_BEQ, op, fn, 0, 0, 1'b1, ok); end
        if (ok) begin encode(K_BEQ, op, fn); applyStimulus(K_BEQ, op, fn, 0, 0, 1'b0, ok); end
        if (ok) begin encode(K_JAL, op, fn); applyStimulus(K_JAL, op, fn, 0, 0, 1'b0, ok); end
        if (ok) begin encode(K_JR, op, fn);  applyStimulus(K_JR,  op, fn, 0, 0, 1'b0, ok); end
        if (ok) applyStimulus(K_ILL, 6'h3F, 6'h00, 0, 0, 1'b0, ok);
        if (ok) begin encode(K_SW, op, fn);  applyStimulus(K_SW,  op, fn, 1, 2, 1'b0, ok); end

        if (ok) begin
            resetMidMemAcc();
            encode(K_ORI, op, fn);
            applyStimulus(K_ORI, op, fn, 0, 0, 1'b0, ok);
        end

        for (int i = 0; i < 200 && ok; i++) begin
            k = kind_e'($urandom_range(0, 9));
            encode(k, op, fn);
            applyStimulus(k, op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), ok);
        end

        if (ok) begin
            #1;
            checkOutput("final_retired_cnt", 32'(bus.retired_cnt), 32'(cntModel));
            checkOutput("scoreboard_drained", 32'(expQ.size()), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle FSM controller for the MIPS-lite datapath: addu, subu, ori, lw, sw, beq, lui, jal, jr.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives PC, IR, GRF and DM write enables, ALU/EXT ops and datapath mux selects.
- Handshakes with instruction and data memories that may insert wait states.
- Sits between the IR/ALU flags and the shared single-ALU datapath; it replaces the single-cycle decoder.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0].
- zero  in  1  ALU equal flag, valid in BRANCH.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data access request.
- IRWE  out  1  IR load.
- PCWE  out  1  PC update.
- GRFWE  out  1  register file write.
- DMWE  out  1  data memory write (qualifies dmem_req).
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump.
- NPCIMM_MUXOp  out  2  01 imm26 (jal), 10 GRF[rs] (jr).
- ALUOp  out  3  001 add, 010 sub, 011 or.
- EXTOp  out  3  001 zero-extend, 010 sign-extend, 011 sign-extend shifted by 2, 100 lui.
- ALUB_MUXOp  out  1  0 EXT, 1 GRF[rt].
- GRFA3_MUXOp  out  2  00 rt, 01 rd, 10 $31.
- GRFWD_MUXOp  out  2  00 ALU, 01 DM, 10 EXT, 11 PC+4.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse when an undefined opcode/func is decoded.
- retired_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- States: FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_ACC, MEM_WB, BRANCH, JUMP.
- Reset (asserted low, asynchronous): state goes to FETCH, the latched class clears, retired_cnt is 0. Every output reads 0 while reset is asserted, including imem_req.
- Outputs are Moore: decoded from the current state and the instruction class latched in DECODE, with two exceptions. IRWE/PCWE/GRFWE gated by a ready input in wait states are combinational with that ready. BRANCH NPCOp follows zero.
- FETCH:
  - imem_req=1.
  - If imem_ready=0, stay in FETCH.
  - If imem_ready=1, IRWE=1 and go to DECODE.
- DECODE:
  - Latch the class from opcode/func.
  - addu/subu/ori/lui go to EXEC.
  - lw/sw go to MEM_ADDR.
  - beq goes to BRANCH.
  - jal/jr go to JUMP.
  - Undefined: illegal=1, PCWE=1, NPCOp=00, no retire, go to FETCH.
- EXEC: drive ALUOp/EXTOp/ALUB_MUXOp per class; go to ALU_WB.
  - addu: ALUOp 001, ALUB 1.
  - subu: ALUOp 010, ALUB 1.
  - ori: ALUOp 011, EXTOp 001, ALUB 0.
  - lui: EXTOp 100.
- ALU_WB:
  - GRFWE=1 and PCWE=1 with NPCOp 00.
  - GRFA3 is 01 for addu/subu, otherwise 00.
  - GRFWD is 10 for lui, otherwise 00.
  - Hold the EXEC ALU/EXT controls.
  - retire=1; go to FETCH.
- MEM_ADDR: ALUOp 001, EXTOp 010, ALUB 0; go to MEM_ACC.
- MEM_ACC:
  - dmem_req=1; DMWE=1 for sw. Hold the address controls.
  - If dmem_ready=0, stay.
  - On dmem_ready with lw, go to MEM_WB.
  - On dmem_ready with sw, PCWE=1 and retire=1, go to FETCH.
- MEM_WB: GRFWE=1, GRFA3 00, GRFWD 01, PCWE=1, retire=1; go to FETCH.
- BRANCH: ALUOp 010, ALUB 1, EXTOp 011, PCWE=1, NPCOp = zero ? 01 : 00, retire=1; go to FETCH.
- JUMP:
  - PCWE=1, NPCOp 10.
  - NPCIMM is 01 for jal and 10 for jr.
  - jal also drives GRFWE=1, GRFA3 10, GRFWD 11.
  - retire=1; go to FETCH.
- Latency with zero-wait memories:
  - addu/subu/ori/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/jal/jr: 3 cycles.
  - Each memory wait cycle adds 1.
- Exactly one PCWE pulse per instruction, including illegal ones.
- GRFWE and DMWE are never both 1.
- retired_cnt increments on retire and wraps modulo 2^CNT_W.
- A ready input outside its wait state is ignored.
- Reset asserted mid-instruction aborts it with no write-enable pulse.
- Deassertion resumes at FETCH.

Decomposition:
- Shared package: state encoding, instruction-class encoding, opcode/func constants, and the NPCOp/ALUOp/EXTOp/mux select constants above. The datapath muxes use the same constants.
- One sub-module: instr_class_decode, a combinational opcode/func to one-hot class decoder with an illegal flag.
- The FSM, output decode and counter stay in the top module.

Test Plan:
- Reset low mid-MEM_ACC with dmem_ready=0 -> all outputs 0 immediately; after release: FETCH with imem_req=1 and retired_cnt=0.
- addu (000000/100001), zero-wait -> IRWE at cycle 1; GRFWE, GRFA3=01, PCWE, retire at cycle 4; retired_cnt=1.
- lw with imem_ready held low 2 cycles and dmem_ready low 3 cycles -> 10 cycles total; dmem_req high 4 cycles with DMWE=0; GRFWD=01 on writeback.
- beq with zero=1, then beq with zero=0 -> NPCOp 01, then 00, each in cycle 3 with EXTOp 011; no GRFWE.
- jal then jr -> jal: GRFWE, GRFA3=10, GRFWD=11, NPCIMM=01; jr: GRFWE=0, NPCIMM=10; both NPCOp=10.
- opcode 111111 -> illegal pulse in DECODE, PCWE with NPCOp 00, no retire, no GRFWE/DMWE; next FETCH follows.
